brc_comparator_iter: RTL and testbench

Parametrised, multi-cycle branch comparator: the successor to the single-cycle 32-bit signed comparator in the branch unit. It compares two WIDTH-bit operands, signed or unsigned per transaction, CHUNK bits per cycle from the most-significant chunk down, and exits early on the first differing chunk. It sits between the register-read stage and branch-decision logic in area-constrained multi-cycle cores. Valid/ready handshakes on both sides allow stalling in either direction.

---
 rtl/brc_pkg.sv | 24 ++
 rtl/brc_chunk_cmp.sv | 28 ++
 rtl/brc_comparator_iter.sv | 120 ++++++++++++
 tb/tb_brc_comparator_iter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brc_pkg.sv
// Shared types and elaboration helpers for the iterative branch comparator.
// Chunk geometry is derived once here so every file agrees on it.
package brc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } brc_state_e;

    function automatic int brc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // idx needs at least one bit even when there is a single chunk
    function automatic int brc_idx_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

    function automatic bit brc_geom_ok(input int width, input int chunk);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/brc_chunk_cmp.sv
// Combinational CHUNK-bit magnitude compare with optional MSB inversion,
// which turns an unsigned compare into a two's-complement one.
module brc_chunk_cmp
    import brc_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             flip_msb,
    output logic             eq,
    output logic             lt
);

    logic [CHUNK-1:0] w_xf;
    logic [CHUNK-1:0] w_yf;

    always_comb begin
        w_xf            = x;
        w_yf            = y;
        w_xf[CHUNK-1]   = x[CHUNK-1] ^ flip_msb;
        w_yf[CHUNK-1]   = y[CHUNK-1] ^ flip_msb;
    end

    assign eq = (x == y);
    assign lt = (w_xf < w_yf);

endmodule

// File: rtl/brc_comparator_iter.sv
// Multi-cycle branch comparator: walks operand chunks MSB-first and
// stops at the first differing chunk, with valid/ready on both sides.
module brc_comparator_iter
    import brc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_unsigned,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             A_eq_B,
    output logic             A_lt_B
);

    localparam int NCHUNK = brc_nchunk(WIDTH, CHUNK);
    localparam int IDXW   = brc_idx_w(NCHUNK);
    localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

    if (!brc_geom_ok(WIDTH, CHUNK)) begin : g_bad_geom
        $error("brc_comparator_iter: WIDTH must be a multiple of CHUNK");
    end

    brc_state_e                   r_state;
    logic [IDXW-1:0]              r_idx;
    logic [NCHUNK-1:0][CHUNK-1:0] r_a;
    logic [NCHUNK-1:0][CHUNK-1:0] r_b;
    logic                         r_uns;
    logic                         r_eq;
    logic                         r_lt;
    logic                         r_out_valid;
    logic                         r_in_ready;

    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic             w_flip;
    logic             w_eq;
    logic             w_lt;

    assign w_a_chunk = r_a[r_idx];
    assign w_b_chunk = r_b[r_idx];
    // Only the top chunk carries the sign bit
    assign w_flip    = !r_uns && (r_idx == LAST);

    brc_chunk_cmp #(
        .CHUNK    (CHUNK)
    ) u_cmp (
        .x        (w_a_chunk),
        .y        (w_b_chunk),
        .flip_msb (w_flip),
        .eq       (w_eq),
        .lt       (w_lt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_uns       <= 1'b0;
            r_eq        <= 1'b0;
            r_lt        <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_uns      <= is_unsigned;
                        r_idx      <= LAST;
                        r_in_ready <= 1'b0;
                        r_state    <= CMP;
                    end
                end
                CMP: begin
                    if (!w_eq) begin
                        r_eq        <= 1'b0;
                        r_lt        <= w_lt;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else if (r_idx == '0) begin
                        r_eq        <= 1'b1;
                        r_lt        <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign A_eq_B    = r_eq;
    assign A_lt_B    = r_lt;

endmodule

// File: tb/tb_brc_comparator_iter.sv
// Directed and random checks for brc_comparator_iter at WIDTH=32, CHUNK=8.
// Inputs change at #1 after posedge or on negedge; outputs sampled at #1.
module tb_brc_comparator_iter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        is_unsigned;
    logic        out_valid;
    logic        out_ready;
    logic        A_eq_B;
    logic        A_lt_B;

    int n_checks;
    int n_errors;

    brc_comparator_iter #(
        .WIDTH       (32),
        .CHUNK       (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .is_unsigned (is_unsigned),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .A_eq_B      (A_eq_B),
        .A_lt_B      (A_lt_B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one transaction; m = cycles from acceptance to out_valid (0 = timeout)
    task automatic run_txn(input logic [31:0] ta, input logic [31:0] tb,
                           input logic tu, input bit hold,
                           output logic req, output logic rlt, output int m);
        int w;
        @(negedge clk);
        a = ta;
        b = tb;
        is_unsigned = tu;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        m = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                m = k;
                break;
            end
        end
        req = A_eq_B;
        rlt = A_lt_B;
        if (!hold) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_hs got ov=%b ir=%b exp ov=0 ir=1",
                     out_valid, in_ready);
        end
        n_checks++;
        if (A_eq_B !== 1'b0 || A_lt_B !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_res got eq=%b lt=%b exp 0 0", A_eq_B, A_lt_B);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset got ir=%b ov=%b exp 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed;
        logic eq, lt;
        int   m;
        run_txn(32'd5, 32'd5, 1'b0, 1'b0, eq, lt, m);
        n_checks++;
        if (eq !== 1'b1 || lt !== 1'b0 || m != 4) begin
            n_errors++;
            $display("FAIL eq5 got eq=%b lt=%b m=%0d exp 1 0 4", eq, lt, m);
        end
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_ready got ir=%b ov=%b exp 1 0", in_ready, out_valid);
        end
        run_txn(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, eq, lt, m);
        n_checks++;
        if (eq !== 1'b0 || lt !== 1'b1 || m != 1) begin
            n_errors++;
            $display("FAIL neg1_s got eq=%b lt=%b m=%0d exp 0 1 1", eq, lt, m);
        end
        run_txn(32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, eq, lt, m);
        n_checks++;
        if (eq !== 1'b0 || lt !== 1'b0 || m != 1) begin
            n_errors++;
            $display("FAIL neg1_u got eq=%b lt=%b m=%0d exp 0 0 1", eq, lt, m);
        end
        run_txn(32'h12345678, 32'h12345679, 1'b1, 1'b0, eq, lt, m);
        n_checks++;
        if (eq !== 1'b0 || lt !== 1'b1 || m != 4) begin
            n_errors++;
            $display("FAIL lowdiff_u got eq=%b lt=%b m=%0d exp 0 1 4", eq, lt, m);
        end
        run_txn(32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0, eq, lt, m);
        n_checks++;
        if (eq !== 1'b0 || lt !== 1'b1 || m != 1) begin
            n_errors++;
            $display("FAIL minint_s got eq=%b lt=%b m=%0d exp 0 1 1", eq, lt, m);
        end
        run_txn(32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, eq, lt, m);
        n_checks++;
        if (eq !== 1'b0 || lt !== 1'b0 || m != 1) begin
            n_errors++;
            $display("FAIL minint_u got eq=%b lt=%b m=%0d exp 0 0 1", eq, lt, m);
        end
        run_txn(32'h00FF0010, 32'h00FE0020, 1'b0, 1'b0, eq, lt, m);
        n_checks++;
        if (eq !== 1'b0 || lt !== 1'b0 || m != 2) begin
            n_errors++;
            $display("FAIL mid_s got eq=%b lt=%b m=%0d exp 0 0 2", eq, lt, m);
        end
    endtask

    task automatic test_backpressure;
        logic eq, lt;
        int   m;
        run_txn(32'h00001000, 32'h00002000, 1'b1, 1'b1, eq, lt, m);
        n_checks++;
        if (eq !== 1'b0 || lt !== 1'b1 || m != 3) begin
            n_errors++;
            $display("FAIL bp_res got eq=%b lt=%b m=%0d exp 0 1 3", eq, lt, m);
        end
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                a = 32'h7FFFFFFF;
                b = 32'h00000000;
                is_unsigned = 1'b0;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                A_eq_B !== 1'b0 || A_lt_B !== 1'b1) begin
                n_errors++;
                $display("FAIL bp_hold c=%0d got ov=%b ir=%b eq=%b lt=%b exp 1 0 0 1",
                         c, out_valid, in_ready, A_eq_B, A_lt_B);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_ignored got ir=%b ov=%b exp 1 0", in_ready, out_valid);
        end
        run_txn(32'hFFFFFF00, 32'hFFFFFF01, 1'b0, 1'b0, eq, lt, m);
        n_checks++;
        if (eq !== 1'b0 || lt !== 1'b1 || m != 4) begin
            n_errors++;
            $display("FAIL bp_next got eq=%b lt=%b m=%0d exp 0 1 4", eq, lt, m);
        end
    endtask

    task automatic test_reset_mid;
        logic eq, lt;
        int   m;
        @(negedge clk);
        a = 32'd0;
        b = 32'd0;
        is_unsigned = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_mid got ov=%b ir=%b exp 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL rst_stale got ov=%b ir=%b exp 0 1", out_valid, in_ready);
            end
        end
        run_txn(32'd3, 32'd7, 1'b0, 1'b0, eq, lt, m);
        n_checks++;
        if (eq !== 1'b0 || lt !== 1'b1 || m != 4) begin
            n_errors++;
            $display("FAIL rst_next got eq=%b lt=%b m=%0d exp 0 1 4", eq, lt, m);
        end
    endtask

    task automatic test_random;
        logic [31:0] ra, rb;
        logic        ru, eq, lt, xeq, xlt;
        int          m, xm, nbad;
        nbad = 0;
        for (int i = 0; i < 10000; i++) begin
            ra = $urandom;
            rb = $urandom;
            ru = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: rb = ra;
                1: rb[31:8] = ra[31:8];
                2: rb[31:16] = ra[31:16];
                3: rb[31:24] = ra[31:24];
                default: ;
            endcase
            xeq = (ra == rb);
            xlt = ru ? (ra < rb) : ($signed(ra) < $signed(rb));
            xm = 1;
            for (int k = 3; k >= 1; k--) begin
                if (ra[k*8 +: 8] != rb[k*8 +: 8]) break;
                xm++;
            end
            run_txn(ra, rb, ru, 1'b0, eq, lt, m);
            n_checks++;
            if (eq !== xeq || lt !== xlt || m != xm) begin
                n_errors++;
                if (nbad < 10)
                    $display("FAIL rand a=%h b=%h u=%b got eq=%b lt=%b m=%0d exp %b %b %0d",
                             ra, rb, ru, eq, lt, m, xeq, xlt, xm);
                nbad++;
            end
        end
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        a           = '0;
        b           = '0;
        is_unsigned = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
